// File: rtl/sm4_key_expander.sv
// SM4 key schedule: master key in, 32 round keys out on a flat bus.
// R chained rounds per cycle; register file kept in encrypt order, reversed at the output mux.
package sm4_encryptor_pkg;
  localparam logic [127:0] key_xor_mask_p = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [31:0] key_aux_p [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279};

  localparam logic [7:0] sbox_p [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};
endpackage

// One key-schedule round: K(i+4) = K(i) ^ L'(tau(K(i+1)^K(i+2)^K(i+3)^CK(i))).
module sm4_key_round
  import sm4_encryptor_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] ck,
  output logic [31:0] k4
);
  logic [31:0] x, b;
  assign x  = k1 ^ k2 ^ k3 ^ ck;
  assign b  = {sbox_p[x[31:24]], sbox_p[x[23:16]], sbox_p[x[15:8]], sbox_p[x[7:0]]};
  assign k4 = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
endmodule

module sm4_key_expander
  import sm4_encryptor_pkg::*;
#(
  parameter int unsigned rounds_per_cycle_p = 1,
  parameter bit          out_reg_p          = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          key_v_i,
  output logic          key_ready_o,
  input  logic [127:0]  key_i,
  input  logic          decrypt_i,
  input  logic          clear_i,
  output logic          rk_v_o,
  input  logic          rk_yumi_i,
  output logic [1023:0] rk_o,
  output logic          busy_o
);
  localparam int R = rounds_per_cycle_p;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16 || R == 32)) begin : g_bad_r
    $error("sm4_key_expander: rounds_per_cycle_p must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e              state_q, state_d;
  logic                load, step;
  logic [5:0]          cnt_q;
  logic                dec_q;
  logic [0:3][31:0]    win_q, win_last;
  logic [R-1:0][31:0]  rnd_k;
  logic [31:0][31:0]   rk_mem_q;
  logic [31:0][31:0]   rk_mux;

  // Sliding window K(i)..K(i+3) threaded through R chained rounds.
  for (genvar g = 0; g < R; g++) begin : g_rnd
    logic [0:3][31:0] win_in, win_out;
    logic [31:0]      k4;
    if (g == 0) begin : g_first
      assign win_in = win_q;
    end else begin : g_next
      assign win_in = g_rnd[g-1].win_out;
    end
    sm4_key_round u_rnd (
      .k0 (win_in[0]),
      .k1 (win_in[1]),
      .k2 (win_in[2]),
      .k3 (win_in[3]),
      .ck (key_aux_p[cnt_q[4:0] + 5'(g)]),
      .k4 (k4)
    );
    assign win_out  = {win_in[1], win_in[2], win_in[3], k4};
    assign rnd_k[g] = k4;
  end
  assign win_last = g_rnd[R-1].win_out;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
        dec_q <= decrypt_i;
        win_q <= key_i ^ key_xor_mask_p;
      end else if (step) begin
        cnt_q <= cnt_q + 6'(R);
        win_q <= win_last;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rk_mem_q <= '0;
    end else if (step) begin
      for (int g = 0; g < R; g++) rk_mem_q[cnt_q[4:0] + 5'(g)] <= rnd_k[g];
    end
  end

  // clear_i outranks everything; leaving DONE needs a yumi against a visible valid.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!clear_i && key_v_i) begin
          state_d = EXPAND;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        if (clear_i) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q + 6'(R) == 6'd32) state_d = DONE;
        end
      end
      DONE: begin
        if (clear_i || (rk_yumi_i && rk_v_o)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == EXPAND);

  always_comb begin
    rk_mux = '0;
    for (int j = 0; j < 32; j++) rk_mux[j] = dec_q ? rk_mem_q[5'(31 - j)] : rk_mem_q[j];
  end

  if (out_reg_p) begin : g_oreg
    logic          out_v_q;
    logic [1023:0] out_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        out_v_q <= 1'b0;
        out_q   <= '0;
      end else if (clear_i) begin
        out_v_q <= 1'b0;
      end else if (out_v_q) begin
        if (rk_yumi_i) out_v_q <= 1'b0;
      end else if (state_q == DONE) begin
        out_v_q <= 1'b1;
        out_q   <= rk_mux;
      end
    end
    assign rk_v_o = out_v_q;
    assign rk_o   = out_q;
  end else begin : g_comb_out
    assign rk_v_o = (state_q == DONE);
    assign rk_o   = rk_mux;
  end
endmodule

// File: tb/tb_sm4_key_expander.sv
// Scoreboard bench for sm4_key_expander: directed R=1 instance plus an unroll/out_reg sweep
// checked against an array-based SM4 key-schedule model.
module tb_sm4_key_expander;
  localparam int NSW = 6;
  localparam int SW_R [NSW] = '{2, 4, 8, 32, 1, 16};
  localparam int SW_O [NSW] = '{0, 1, 0, 1, 1, 0};
  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};

  typedef struct {
    logic [1023:0] rk;
    int            acc;
    int            lat;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic key_v = 1'b0, key_ready, dec = 1'b0, clear = 1'b0, rk_v, rk_yumi = 1'b0, busy;
  logic [127:0]  key = '0;
  logic [1023:0] rk_o;

  logic                      sw_key_v = 1'b0, sw_dec = 1'b0;
  logic [127:0]              sw_key = '0;
  logic [NSW-1:0]            sw_ready, sw_rk_v, sw_busy;
  logic [NSW-1:0][1023:0]    sw_rk_o;

  ent_t exp_q[$];
  ent_t sw_q [NSW][$];
  int   chk_cnt = 0, pass_cnt = 0, cyc = 0;
  logic v_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm4_key_expander #(.rounds_per_cycle_p(1), .out_reg_p(1'b0)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .key_v_i(key_v), .key_ready_o(key_ready), .key_i(key),
    .decrypt_i(dec), .clear_i(clear), .rk_v_o(rk_v), .rk_yumi_i(rk_yumi), .rk_o(rk_o), .busy_o(busy));

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tp(logic [31:0] x);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = SBOX[x[8*i +: 8]];
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [31:0] ck(int i);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  function automatic logic [1023:0] ref_rk(logic [127:0] mk, logic d);
    logic [31:0]   k [36];
    logic [1023:0] r;
    for (int j = 0; j < 4; j++) k[j] = mk[127 - 32*j -: 32] ^ FK[j];
    for (int i = 0; i < 32; i++) k[i+4] = k[i] ^ tp(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
    for (int j = 0; j < 32; j++) r[32*j +: 32] = d ? k[4 + 31 - j] : k[4 + j];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void chk_rk(string nm, logic [1023:0] act, logic [1023:0] exp);
    int s = 0;
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      for (int j = 31; j >= 0; j--) if (act[32*j +: 32] !== exp[32*j +: 32]) s = j;
      $display("FAIL %s: slot %0d got %h expected %h", nm, s, act[32*s +: 32], exp[32*s +: 32]);
    end
  endfunction

  function automatic void fail(string nm);
    chk_cnt++;
    $display("FAIL %s: got unexpected/missing event expected clean handshake", nm);
  endfunction

  function automatic int sw_pending();
    int n = 0;
    for (int k = 0; k < NSW; k++) n += sw_q[k].size();
    return n;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rk_v && !v_prev) begin
      if (exp_q.size() == 0) fail("spurious_valid");
      else begin
        chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
        chk_rk("rk_first", rk_o, exp_q[0].rk);
      end
    end
    if (rk_v && rk_yumi && exp_q.size() != 0) begin
      chk_rk("rk_handshake", rk_o, exp_q[0].rk);
      void'(exp_q.pop_front());
    end
    v_prev <= rk_v;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(key_v && !key_ready)) else $error("protocol: key_v while key_ready low");
      assert (!(rk_yumi && !rk_v)) else $error("protocol: rk_yumi while rk_v low");
    end
  end

  for (genvar k = 0; k < NSW; k++) begin : g_sw
    sm4_key_expander #(.rounds_per_cycle_p(SW_R[k]), .out_reg_p(SW_O[k] != 0)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .key_v_i(sw_key_v), .key_ready_o(sw_ready[k]), .key_i(sw_key),
      .decrypt_i(sw_dec), .clear_i(1'b0), .rk_v_o(sw_rk_v[k]), .rk_yumi_i(sw_rk_v[k]),
      .rk_o(sw_rk_o[k]), .busy_o(sw_busy[k]));

    always @(negedge clk) begin
      if (sw_rk_v[k]) begin
        if (sw_q[k].size() == 0) fail($sformatf("sw%0d_spurious", k));
        else begin
          chk($sformatf("sw%0d_latency", k), 64'(cyc - sw_q[k][0].acc), 64'(sw_q[k][0].lat));
          chk_rk($sformatf("sw%0d_rk", k), sw_rk_o[k], sw_q[k][0].rk);
          void'(sw_q[k].pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [127:0] mk, input logic d);
    int t = 0;
    while (!key_ready && t < 100) begin tick(); t++; end
    if (!key_ready) begin fail("ready_timeout"); return; end
    key = mk; dec = d; key_v = 1'b1;
    tick();
    key_v = 1'b0;
    exp_q.push_back('{ref_rk(mk, d), cyc, 32});
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!rk_v && t < 100) begin tick(); t++; end
    if (!rk_v) fail("valid_timeout");
  endtask

  task automatic consume();
    rk_yumi = 1'b1;
    tick();
    rk_yumi = 1'b0;
  endtask

  task automatic full_key(input logic [127:0] mk, input logic d);
    issue(mk, d);
    wait_valid();
    if (rk_v) consume();
  endtask

  task automatic async_reset_check(string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_ready"}, key_ready, 1);
    chk({tag, "_rk_v"}, rk_v, 0);
    chk({tag, "_busy"}, busy, 0);
    chk_rk({tag, "_rk_o"}, rk_o, '0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  localparam logic [127:0] KAT = 128'h0123456789abcdeffedcba9876543210;

  initial begin
    logic [1023:0] snap;
    bit            ok, okr;
    int            t;

    #12;
    chk("rst_ready", key_ready, 1);
    chk("rst_rk_v", rk_v, 0);
    chk("rst_busy", busy, 0);
    chk_rk("rst_rk_o", rk_o, '0);
    chk("rst_sw_ready", 64'(sw_ready), 64'({NSW{1'b1}}));
    tick();
    rst_n = 1'b1;
    tick();

    // known-answer encrypt
    issue(KAT, 1'b0);
    chk("busy_in_expand", busy, 1);
    chk("ready_in_expand", key_ready, 0);
    wait_valid();
    chk("kat_enc_slot0", rk_o[31:0], 32'hF12186F9);
    chk("kat_enc_slot1", rk_o[63:32], 32'h41662B61);
    chk("kat_enc_slot31", rk_o[1023:992], 32'h9124A012);
    consume();

    // known-answer decrypt; decrypt_i changing after acceptance must not matter
    issue(KAT, 1'b1);
    dec = 1'b0;
    wait_valid();
    chk("kat_dec_slot0", rk_o[31:0], 32'h9124A012);
    chk("kat_dec_slot31", rk_o[1023:992], 32'hF12186F9);
    consume();

    // back-pressure then back-to-back key
    issue({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
    wait_valid();
    snap = exp_q[0].rk;
    ok = 1'b1; okr = 1'b1;
    repeat (20) begin
      if (rk_o !== snap || !rk_v) ok = 1'b0;
      if (key_ready) okr = 1'b0;
      tick();
    end
    chk("bp_stable", ok, 1);
    chk("bp_ready_low", okr, 1);
    consume();
    chk("ready_after_yumi", key_ready, 1);
    full_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));

    // abort mid-expand
    issue({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_ready", key_ready, 1);
    chk("abort_busy", busy, 0);
    void'(exp_q.pop_back());
    ok = 1'b1;
    repeat (40) begin if (rk_v) ok = 1'b0; tick(); end
    chk("abort_no_valid", ok, 1);
    full_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // clear and key together in IDLE: key rejected
    key = {$urandom, $urandom, $urandom, $urandom};
    key_v = 1'b1; clear = 1'b1;
    tick();
    key_v = 1'b0; clear = 1'b0;
    chk("clr_key_busy", busy, 0);
    chk("clr_key_ready", key_ready, 1);
    ok = 1'b1;
    repeat (35) begin if (rk_v || busy) ok = 1'b0; tick(); end
    chk("clr_key_idle", ok, 1);
    full_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // asynchronous reset mid-expand and in DONE
    issue({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (5) tick();
    async_reset_check("arst_expand");
    full_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    issue({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_valid();
    async_reset_check("arst_done");
    full_key(KAT, 1'b0);

    // unroll / output-register sweep on shared random keys
    for (int n = 0; n < 8; n++) begin
      t = 0;
      while ((sw_pending() != 0 || sw_ready != {NSW{1'b1}}) && t < 200) begin tick(); t++; end
      if (t >= 200) begin fail("sw_timeout"); break; end
      sw_key = {$urandom, $urandom, $urandom, $urandom};
      sw_dec = 1'($urandom);
      sw_key_v = 1'b1;
      tick();
      sw_key_v = 1'b0;
      for (int k = 0; k < NSW; k++)
        sw_q[k].push_back('{ref_rk(sw_key, sw_dec), cyc, 32 / SW_R[k] + SW_O[k]});
    end
    t = 0;
    while (sw_pending() != 0 && t < 200) begin tick(); t++; end
    if (sw_pending() != 0) fail("sw_drain_timeout");
    if (exp_q.size() != 0) fail("main_drain");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
